reg_arbiter: RTL and testbench

REG_ARBITER -- requirements
Module: reg_arbiter

---
 rtl/reg_arbiter_if.sv | 32 +++
 rtl/reg_arbiter.sv | 108 ++++++++++
 tb/tb_reg_arbiter.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/reg_arbiter_if.sv
// Requester-side and register-bus signals of reg_arbiter bundled together.
// slave: arbiter view. master: requesters plus register block view.
interface reg_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int AW      = 2,
    parameter int W_WIDTH = 8
);
    logic [NUM_REQ-1:0]         req;
    logic [NUM_REQ-1:0]         req_wr_rd_s;
    logic [NUM_REQ*AW-1:0]      req_addr;
    logic [NUM_REQ*W_WIDTH-1:0] req_wr_data;
    logic [NUM_REQ-1:0]         gnt;
    logic [NUM_REQ-1:0]         done;
    logic [W_WIDTH-1:0]         rsp_rd_data;
    logic                       rsp_err;
    logic                       sel_en;
    logic                       wr_rd_s;
    logic [AW-1:0]              addr;
    logic [W_WIDTH-1:0]         wr_data;
    logic [W_WIDTH-1:0]         rd_data;
    logic                       ack;

    modport slave (
        input  req, req_wr_rd_s, req_addr, req_wr_data, rd_data, ack,
        output gnt, done, rsp_rd_data, rsp_err, sel_en, wr_rd_s, addr, wr_data
    );

    modport master (
        output req, req_wr_rd_s, req_addr, req_wr_data, rd_data, ack,
        input  gnt, done, rsp_rd_data, rsp_err, sel_en, wr_rd_s, addr, wr_data
    );
endinterface

// File: rtl/reg_arbiter.sv
// Round-robin sharing of one register bus; BUSY timeout only when REG_ARB_TIMEOUT_EN is defined.
// Latency: command on bus one edge after req seen in IDLE; done one edge after ack (or timeout).
// Backpressure: requesters hold req until done; bus waits on ack; IDLE+DONE gap between commands.
module reg_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int NUM_OF_PORTS   = 4,
    parameter int W_WIDTH        = 8,
    parameter int TIMEOUT_CYCLES = 15
) (
    input logic          clk,
    input logic          rst,
    reg_arbiter_if.slave bus
);
    localparam int AW = (NUM_OF_PORTS > 1) ? $clog2(NUM_OF_PORTS) : 1;
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state;
    logic [IW-1:0] last_gnt;
    logic [IW-1:0] cur;
    logic [IW-1:0] pick;
    logic [IW-1:0] cand;
    logic          pick_vld;
`ifdef REG_ARB_TIMEOUT_EN
    logic [7:0]    tmo_cnt;
`endif

    // Walk from farthest to nearest so the nearest requester after last_gnt wins.
    always_comb begin
        pick     = '0;
        cand     = '0;
        pick_vld = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = IW'((int'(last_gnt) + k) % NUM_REQ);
            if (bus.req[cand]) begin
                pick     = cand;
                pick_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            last_gnt        <= IW'(NUM_REQ - 1);
            cur             <= '0;
            bus.sel_en      <= 1'b0;
            bus.gnt         <= '0;
            bus.done        <= '0;
            bus.rsp_err     <= 1'b0;
            bus.rsp_rd_data <= '0;
            bus.wr_rd_s     <= 1'b0;
            bus.addr        <= '0;
            bus.wr_data     <= '0;
`ifdef REG_ARB_TIMEOUT_EN
            tmo_cnt         <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        state       <= BUSY;
                        cur         <= pick;
                        bus.sel_en  <= 1'b1;
                        bus.gnt     <= NUM_REQ'(1) << pick;
                        bus.wr_rd_s <= bus.req_wr_rd_s[pick];
                        bus.addr    <= bus.req_addr[int'(pick)*AW +: AW];
                        bus.wr_data <= bus.req_wr_data[int'(pick)*W_WIDTH +: W_WIDTH];
`ifdef REG_ARB_TIMEOUT_EN
                        tmo_cnt     <= '0;
`endif
                    end
                end
                BUSY: begin
                    if (bus.ack) begin
                        if (!bus.wr_rd_s) begin
                            bus.rsp_rd_data <= bus.rd_data;
                        end
                        bus.rsp_err <= 1'b0;
                        bus.sel_en  <= 1'b0;
                        bus.done    <= bus.gnt;
                        last_gnt    <= cur;
                        state       <= DONE;
                    end
`ifdef REG_ARB_TIMEOUT_EN
                    // Ack on the final allowed cycle takes priority over the timeout.
                    else if (tmo_cnt == 8'(TIMEOUT_CYCLES - 1)) begin
                        bus.rsp_err <= 1'b1;
                        bus.sel_en  <= 1'b0;
                        bus.done    <= bus.gnt;
                        last_gnt    <= cur;
                        state       <= DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
`endif
                end
                DONE: begin
                    bus.done <= '0;
                    bus.gnt  <= '0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_reg_arbiter.sv
// Randomized bench for reg_arbiter: the bench plays requesters and register block and checks
// each transaction against a round-robin / response model kept at transaction level.
module tb_reg_arbiter;
    localparam int NR  = 4;
    localparam int NP  = 4;
    localparam int W   = 8;
    localparam int TO  = 15;
    localparam int AW  = 2;
    localparam int AWT = NR * AW;
    localparam int WDT = NR * W;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    reg_arbiter_if #(.NUM_REQ(NR), .AW(AW), .W_WIDTH(W)) bus ();

    reg_arbiter #(
        .NUM_REQ(NR), .NUM_OF_PORTS(NP), .W_WIDTH(W), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    int            last_g;
    logic [NR-1:0] pend;
    logic          dir [NR];
    logic [AW-1:0] a   [NR];
    logic [W-1:0]  wd  [NR];
    logic [W-1:0]  rsp_model;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int rr_pick(input int last, input logic [NR-1:0] m);
        for (int k = 1; k <= NR; k++) begin
            if (m[(last + k) % NR]) return (last + k) % NR;
        end
        return -1;
    endfunction

    task automatic drive_req();
        bus.req = pend;
        for (int i = 0; i < NR; i++) begin
            bus.req_wr_rd_s[i]          = dir[i];
            bus.req_addr[i*AW +: AW]    = a[i];
            bus.req_wr_data[i*W +: W]   = wd[i];
        end
    endtask

    task automatic set_req(input int i, input logic d, input logic [AW-1:0] ad, input logic [W-1:0] dat);
        pend[i] = 1'b1;
        dir[i]  = d;
        a[i]    = ad;
        wd[i]   = dat;
    endtask

    task automatic new_requests();
        for (int i = 0; i < NR; i++) begin
            if (!pend[i] && $urandom_range(0, 1) == 1)
                set_req(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, NP-1)), W'($urandom));
        end
        if (pend == '0)
            set_req($urandom_range(0, NR-1), 1'($urandom_range(0, 1)),
                    AW'($urandom_range(0, NP-1)), W'($urandom));
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_sel_en"},  32'(bus.sel_en), 32'd0);
        check({tag, "_gnt"},     32'(bus.gnt), 32'd0);
        check({tag, "_done"},    32'(bus.done), 32'd0);
        check({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'd0);
        check({tag, "_rsp_rd"},  32'(bus.rsp_rd_data), 32'd0);
        check({tag, "_wr_rd_s"}, 32'(bus.wr_rd_s), 32'd0);
        check({tag, "_addr"},    32'(bus.addr), 32'd0);
        check({tag, "_wr_data"}, 32'(bus.wr_data), 32'd0);
    endtask

    // One arbitration: d = extra BUSY cycles before ack; frd >= 0 forces the read data.
    task automatic txn(input int d, input bit do_rst, input bit hold, input int frd);
        int         w;
        int         blen;
        bit         exp_err;
        logic [W-1:0] rd;
        rd = '0;
        w  = rr_pick(last_g, pend);
        drive_req();
        bus.ack = 1'($urandom_range(0, 1));
        @(negedge clk);
        blen    = d + 1;
        exp_err = 1'b0;
`ifdef REG_ARB_TIMEOUT_EN
        if (d + 1 > TO) begin
            blen    = TO;
            exp_err = 1'b1;
        end
`endif
        for (int c = 1; c <= blen; c++) begin
            check("sel_en_busy", 32'(bus.sel_en), 32'd1);
            check("gnt_busy",    32'(bus.gnt), 32'(1 << w));
            check("done_busy",   32'(bus.done), 32'd0);
            check("wr_rd_s",     32'(bus.wr_rd_s), 32'(dir[w]));
            check("addr",        32'(bus.addr), 32'(a[w]));
            check("wr_data",     32'(bus.wr_data), 32'(wd[w]));
            if (do_rst && c == 2) begin
                rst = 1'b1;
                #1;
                check_outputs_zero("rst_busy");
                @(negedge clk);
                rst     = 1'b0;
                bus.ack = 1'b0;
                pend    = '0;
                drive_req();
                last_g    = NR - 1;
                rsp_model = '0;
                @(negedge clk);
                check("rst_no_done", 32'(bus.done), 32'd0);
                check("rst_no_sel",  32'(bus.sel_en), 32'd0);
                check("rst_no_gnt",  32'(bus.gnt), 32'd0);
                return;
            end
            rd = W'($urandom);
            if (frd >= 0 && c == d + 1) rd = W'(frd);
            bus.ack     = (c == d + 1);
            bus.rd_data = rd;
            if ($urandom_range(0, 2) == 0) begin
                bus.req         = NR'($urandom);
                bus.req_wr_rd_s = NR'($urandom);
                bus.req_addr    = AWT'($urandom);
                bus.req_wr_data = WDT'($urandom);
            end
            @(negedge clk);
        end
        if (!exp_err && !dir[w]) rsp_model = rd;
        check("done_pulse",  32'(bus.done), 32'(1 << w));
        check("sel_en_done", 32'(bus.sel_en), 32'd0);
        check("gnt_done",    32'(bus.gnt), 32'(1 << w));
        check("rsp_err",     32'(bus.rsp_err), 32'(exp_err));
        check("rsp_rd_data", 32'(bus.rsp_rd_data), 32'(rsp_model));
        last_g = w;
        if (!hold) pend[w] = 1'b0;
        bus.ack     = 1'($urandom_range(0, 1));
        bus.rd_data = W'($urandom);
        drive_req();
        @(negedge clk);
        check("done_idle",   32'(bus.done), 32'd0);
        check("gnt_idle",    32'(bus.gnt), 32'd0);
        check("sel_en_idle", 32'(bus.sel_en), 32'd0);
        check("rsp_hold",    32'(bus.rsp_rd_data), 32'(rsp_model));
    endtask

    initial begin
        int dl [10] = '{0, 0, 1, 2, 3, 4, 13, 14, 15, 30};
        int d;
        bit r;
        pend      = '0;
        last_g    = NR - 1;
        rsp_model = '0;
        for (int i = 0; i < NR; i++) begin
            dir[i] = 1'b0;
            a[i]   = '0;
            wd[i]  = '0;
        end
        drive_req();
        bus.ack     = 1'b0;
        bus.rd_data = '0;
        #1 rst = 1'b1;
        #1;
        check_outputs_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Single read from requester 1, ack on the third BUSY cycle.
        set_req(1, 1'b0, AW'(2), W'(8'h00));
        txn(2, 1'b0, 1'b0, 8'hA5);
        // Requester 2 writes 0x3C to address 1; read data must be kept.
        set_req(2, 1'b1, AW'(1), W'(8'h3C));
        txn(1, 1'b0, 1'b0, -1);
        // All four held, immediate ack: order follows the rotation.
        for (int i = 0; i < NR; i++)
            set_req(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, NP-1)), W'($urandom));
        for (int t = 0; t < 5; t++) txn(0, 1'b0, 1'b1, -1);
        pend = '0;
`ifdef REG_ARB_TIMEOUT_EN
        // No ack at all, then the ack/timeout tie on the last allowed cycle.
        set_req(0, 1'b0, AW'(3), W'(8'h11));
        set_req(3, 1'b0, AW'(0), W'(8'h22));
        txn(100, 1'b0, 1'b0, -1);
        txn(TO - 1, 1'b0, 1'b0, 8'h5A);
`endif
        // Reset during the second BUSY cycle, then requester 3 alone.
        new_requests();
        txn(3, 1'b1, 1'b0, -1);
        set_req(3, 1'b1, AW'(2), W'(8'h77));
        txn(0, 1'b0, 1'b0, -1);

        for (int t = 0; t < 40; t++) begin
            new_requests();
            d = dl[$urandom_range(0, 9)];
            r = ($urandom_range(0, 14) == 0);
            if (r && d < 2) d = 2;
            txn(d, r, 1'b0, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
